// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: format codes, opcode[6:2] values,
// immediate range limits and the NOP word.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;
    localparam int SHAMT_MAX = 31;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [6:0] funct7(input logic f7b5);
        return {1'b0, f7b5, 5'b00000};
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// imm_pack: places immediate bits at their instruction-word positions for a
// given format and flags immediates that do not fit that format.
module imm_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (fmt_e'(fmt))
            FMT_I: begin
                imm_bits[31:20] = imm[11:0];
                range_err       = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_SH: begin
                imm_bits[24:20] = imm[4:0];
                range_err       = (simm < 0) || (simm > SHAMT_MAX);
            end
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_err       = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_err       = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
            end
            FMT_U: begin
                imm_bits[31:12] = imm[31:12];
                range_err       = |imm[11:0];
            end
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_err       = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
            end
            FMT_RSV: begin
                range_err = 1'b1;
            end
            default: begin
                range_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder with sequential IMEM write addresses.
// Optional ENC_ROUNDTRIP_EN adds a decode-back immediate self-check.
module inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_err_q, out_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              rt_mismatch_q, rt_mismatch_d;

    logic [31:0] imm_bits;
    logic        range_err;
    logic [31:0] word;
    logic        word_rt_mismatch;
    logic        ready_int;
    logic        accept;

    imm_pack u_imm_pack (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    always_comb begin
        word = '0;
        case (fmt_e'(in_fmt))
            FMT_R:        word = {funct7(in_f7b5), in_rs2, in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
            FMT_I:        word = {12'b0, in_rs1, in_funct3, in_rd, in_opcode, 2'b11} | imm_bits;
            FMT_SH:       word = {funct7(in_f7b5), 5'b0, in_rs1, in_funct3, in_rd, in_opcode, 2'b11} | imm_bits;
            FMT_S, FMT_B: word = {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode, 2'b11} | imm_bits;
            FMT_U, FMT_J: word = {20'b0, in_rd, in_opcode, 2'b11} | imm_bits;
            default:      word = NOP_WORD;
        endcase
    end

`ifdef ENC_ROUNDTRIP_EN
    logic [31:0] rt_imm;
    logic        rt_has_imm;

    always_comb begin
        rt_imm     = '0;
        rt_has_imm = 1'b1;
        case (fmt_e'(in_fmt))
            FMT_I:   rt_imm = {{20{word[31]}}, word[31:20]};
            FMT_SH:  rt_imm = {27'b0, word[24:20]};
            FMT_S:   rt_imm = {{20{word[31]}}, word[31:25], word[11:7]};
            FMT_B:   rt_imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
            FMT_U:   rt_imm = {word[31:12], 12'b0};
            FMT_J:   rt_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
            default: rt_has_imm = 1'b0;
        endcase
        word_rt_mismatch = rt_has_imm && !range_err && (rt_imm != in_imm);
    end
`else
    assign word_rt_mismatch = 1'b0;
`endif

    assign ready_int = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    // start wins over a same-cycle accept; the offered bundle stays pending
    assign accept    = in_valid && ready_int && !start;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_addr_d    = out_addr_q;
        out_err_d     = out_err_q;
        err_sticky_d  = err_sticky_q;
        rt_mismatch_d = rt_mismatch_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (start) begin
            state_d       = ST_RUN;
            addr_d        = ADDR_W'(BASE_ADDR);
            err_sticky_d  = 1'b0;
            rt_mismatch_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = word;
            out_addr_d    = addr_q;
            out_err_d     = range_err;
            rt_mismatch_d = word_rt_mismatch;
            // rt_mismatch is folded into the sticky flag once its word is replaced
            err_sticky_d  = err_sticky_q | rt_mismatch_q | range_err;
            if (addr_q == '1) begin
                state_d = ST_DONE;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_addr_q    <= '0;
            out_err_q     <= 1'b0;
            err_sticky_q  <= 1'b0;
            rt_mismatch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_addr_q    <= out_addr_d;
            out_err_q     <= out_err_d;
            err_sticky_q  <= err_sticky_d;
            rt_mismatch_q <= rt_mismatch_d;
        end
    end

    assign in_ready   = ready_int;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_addr   = out_addr_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q | rt_mismatch_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the immediate-generation/decode path.
- Accepts decoded fields (format, opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake.
- Packs them into legal 32-bit instruction words and range-checks the immediate.
- Emits each word with a sequential instruction-memory write address.
- Used by the self-test program injector and the bench to fill IMEM before the core runs.

Parameters:
ADDR_W, 10, word-address width of the output write address; capacity 2^ADDR_W words.
BASE_ADDR, 0, first word address loaded on start.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  one-cycle pulse: IDLE/DONE -> RUN, addr=BASE_ADDR, clear err_sticky.
in_valid  in  1  field bundle valid.
in_ready  out  1  encoder can accept.
in_fmt  in  3  0=R, 1=I, 2=SH (shift-imm), 3=S, 4=B, 5=U, 6=J, 7=reserved.
in_opcode  in  5  instruction bits [6:2]; bits [1:0] always forced to 2'b11.
in_rd, in_rs1, in_rs2  in  5 each  register indices.
in_funct3  in  3  funct3.
in_f7b5  in  1  instruction bit 30, used for R and SH formats.
in_imm  in  32  signed byte-offset or value immediate.
out_valid  out  1  out_instr/out_addr valid.
out_ready  in  1  IMEM writer accepts.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  word address for out_instr.
out_err  out  1  immediate out of range / reserved format for this word.
err_sticky  out  1  OR of all out_err since start.
done  out  1  high in DONE state.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=0, out_err=0, err_sticky=0, done=0. State is IDLE, addr=0.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: normal operation.
  - DONE: entered when the word at address 2^ADDR_W-1 is accepted on input. in_ready=0, done=1. The last output still drains. start -> RUN. No wrap-around.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Input accepted when in_valid && in_ready. Result is registered and appears one cycle later.
  - out_* hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready when no new input is accepted the same cycle.
  - Full throughput: accept and drain in the same cycle is allowed.
- Address: registered with the word, then incremented on each input accept.
- start while RUN: addr reloads and err_sticky clears. Any pending output is still delivered with its old address. start has priority over a same-cycle accept; that input is not accepted.
- Encoding (bits [1:0]=11, opcode [6:2]):
  - R: f7 = {0, f7b5, 00000}.
  - I: imm[11:0] in [31:20].
  - SH: {0, f7b5, 00000, imm[4:0]}.
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7].
  - U: imm[31:12] in [31:12].
  - J: imm[20|10:1|11|19:12] in [31:12].
  - Fields unused by a format are encoded as zero.
- Range checks set out_err; the word is still emitted with the truncated fields:
  - I/S: -2048..2047.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: imm[11:0]==0.
  - SH: 0..31.
- Reserved format: out_instr=32'h00000013 (NOP), out_err=1.
- Reset mid-operation: immediate return to reset values. Any pending word is lost.

Optional Feature:
ENC_ROUNDTRIP_EN:
- Defined: an internal combinational immediate decoder re-extracts the immediate from the encoded word using the same decode rules as the core. A second status bit, rt_mismatch, is registered with the word and is set when the decoded value differs from in_imm, for in-range words only. It also feeds err_sticky.
- Not defined: rt_mismatch is tied to 0 and no decoder logic is present.

Decomposition:
- Shared package rv_enc_pkg:
  - format code constants FMT_R..FMT_J, FMT_RSV.
  - opcode[6:2] constants OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP.
  - range limit constants.
  - NOP word.
- One combinational sub-module, imm_pack: format + imm -> {field bits, range_err}. The top level holds the FSM, handshake, address and status registers.

Test Plan:
1. ADDI x1,x0,5 (fmt I, op 00100, f3 0, imm 5) -> out_instr 0x00500093, out_addr 0, out_err 0.
2. LUI x2 imm 0x12345000 -> 0x12345137. Repeat with imm 0x12345001 -> out_err=1, err_sticky=1.
3. JAL x1 +8 -> 0x008000EF. BEQ x1,x2,-4 -> 0xFE208EE3. BEQ with imm -3 -> out_err=1.
4. SW x5,12(x2) -> 0x00512623. SRAI x3,x3,4 (f7b5=1, f3 5) -> 0x4041D193. SH with imm 32 -> out_err=1.
5. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable. Release -> back-to-back words at consecutive addresses, one per cycle.
6. ADDR_W=2: start, push 4 words -> addresses 0..3, done=1, in_ready=0. start -> addr 0, err_sticky 0. Assert rst_n low mid-stream -> all outputs 0, state IDLE.
